// File: rtl/mph_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : mph_ctrl_pkg
// Brief    : Register map, field positions and offset decode shared by the
//            multi-project harness Wishbone controller.
//            Optional feature macro: SCRATCH_REG_EN (adds SCRATCH at 0x10).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mph_ctrl_pkg;

  // Word-aligned register offsets within the 256-byte slave window
  localparam logic [7:0] OFS_ACTIVE  = 8'h00;
  localparam logic [7:0] OFS_CTRL    = 8'h04;
  localparam logic [7:0] OFS_COMPARE = 8'h08;
  localparam logic [7:0] OFS_STATUS  = 8'h0C;
  localparam logic [7:0] OFS_SCRATCH = 8'h10;

  // CTRL bit positions
  localparam int CTRL_HOLD_BIT  = 0;
  localparam int CTRL_CLKEN_BIT = 1;

  // STATUS field positions
  localparam int STAT_RST_BIT    = 0;
  localparam int STAT_ACTIVE_LSB = 4;
  localparam int STAT_CNT_LSB    = 8;

  typedef enum logic [2:0] {
    REG_ACTIVE,
    REG_CTRL,
    REG_COMPARE,
    REG_STATUS,
    REG_SCRATCH,
    REG_NONE
  } reg_e;

  // Map a word index (byte offset bits [7:2]) onto a register
  function automatic reg_e decode_word(input logic [5:0] word);
    reg_e r;
    r = REG_NONE;
    case (word)
      OFS_ACTIVE[7:2]:  r = REG_ACTIVE;
      OFS_CTRL[7:2]:    r = REG_CTRL;
      OFS_COMPARE[7:2]: r = REG_COMPARE;
      OFS_STATUS[7:2]:  r = REG_STATUS;
`ifdef SCRATCH_REG_EN
      OFS_SCRATCH[7:2]: r = REG_SCRATCH;
`endif
      default:          r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mph_reset_stretch.sv
//------------------------------------------------------------------------------
// Module   : mph_reset_stretch
// Brief    : 8-bit load/decrement counter that stretches the project reset.
//            Loads RST_CYCLES on load (and out of reset), counts down to 0
//            and saturates there; busy is high while the count is non-zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mph_reset_stretch #(
  parameter int RST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  output logic       busy,
  output logic [7:0] cnt
);

  localparam logic [7:0] RELOAD = 8'(RST_CYCLES);

  logic [7:0] cnt_d;
  logic [7:0] cnt_q;

  // Next count: reload wins over decrement; hold at zero once expired
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Count register; reset value keeps the project in reset after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != 8'd0);

endmodule

`default_nettype wire

// File: rtl/mph_wb_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mph_wb_ctrl
// Brief    : Wishbone register slave in front of the multi-project harness.
//            Drives active-project select, one-hot update strobes, shared
//            compare bus, clock enable and a stretched project reset.
//            Optional feature macro: SCRATCH_REG_EN (32-bit SCRATCH at 0x10).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mph_wb_ctrl
  import mph_ctrl_pkg::*;
#(
  parameter int          NUM_PROJECTS = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          COMPARE_W    = 24,
  parameter int          RST_CYCLES   = 4,
  localparam int         SEL_W        = $clog2(NUM_PROJECTS)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [SEL_W-1:0]        proj_sel_o,
  output logic                    proj_clk_en_o,
  output logic                    proj_reset_o,
  output logic [NUM_PROJECTS-1:0] proj_wb_update_o,
  output logic [COMPARE_W-1:0]    compare_o
);

  localparam logic [4:0]              NUM_P   = 5'(NUM_PROJECTS);
  localparam logic [NUM_PROJECTS-1:0] UPD_ONE = NUM_PROJECTS'(1);

  logic                    ack_d,     ack_q;
  logic [31:0]             dat_d,     dat_q;
  logic [SEL_W-1:0]        sel_d,     sel_q;
  logic                    hold_d,    hold_q;
  logic                    clk_en_d,  clk_en_q;
  logic [COMPARE_W-1:0]    compare_d, compare_q;
  logic [NUM_PROJECTS-1:0] upd_d,     upd_q;
`ifdef SCRATCH_REG_EN
  logic [31:0]             scratch_d, scratch_q;
`endif

  logic       w_hit;
  logic       w_accept;
  logic       w_wr;
  logic       w_rd;
  logic       w_reload;
  logic       w_busy;
  logic [7:0] w_cnt;
  logic [3:0] w_active4;
  logic [31:0] w_status;
  reg_e       w_reg;
  logic       w_unused;

  // Address decode and single-cycle handshake qualification
  always_comb begin
    w_hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    w_accept = w_hit & ~ack_q;
    w_wr     = w_accept & wbs_we_i;
    w_rd     = w_accept & ~wbs_we_i;
    w_reg    = decode_word(wbs_adr_i[7:2]);
  end

  // Read-only STATUS image built from live state
  always_comb begin
    w_active4 = 4'(sel_q);
    w_status  = '0;
    w_status[STAT_RST_BIT]                  = proj_reset_o;
    w_status[STAT_ACTIVE_LSB +: 4]          = w_active4;
    w_status[STAT_CNT_LSB +: 8]             = w_cnt;
  end

  // Register writes, update strobe, reload request and read-data mux
  always_comb begin
    ack_d     = w_accept;
    dat_d     = '0;
    sel_d     = sel_q;
    hold_d    = hold_q;
    clk_en_d  = clk_en_q;
    compare_d = compare_q;
    upd_d     = '0;
    w_reload  = 1'b0;
`ifdef SCRATCH_REG_EN
    scratch_d = scratch_q;
`endif

    if (w_wr) begin
      case (w_reg)
        REG_ACTIVE: begin
          if (wbs_sel_i[0] && ({1'b0, wbs_dat_i[3:0]} < NUM_P) &&
              (wbs_dat_i[SEL_W-1:0] != sel_q)) begin
            sel_d    = wbs_dat_i[SEL_W-1:0];
            w_reload = 1'b1;
          end
        end
        REG_CTRL: begin
          if (wbs_sel_i[0]) begin
            hold_d   = wbs_dat_i[CTRL_HOLD_BIT];
            clk_en_d = wbs_dat_i[CTRL_CLKEN_BIT];
            w_reload = wbs_dat_i[CTRL_HOLD_BIT];
          end
        end
        REG_COMPARE: begin
          for (int i = 0; i < COMPARE_W; i++) begin
            if (wbs_sel_i[i/8]) begin
              compare_d[i] = wbs_dat_i[i];
            end
          end
        end
`ifdef SCRATCH_REG_EN
        REG_SCRATCH: begin
          for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
              scratch_d[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
            end
          end
        end
`endif
        default: ;
      endcase
      // Strobe follows the select as it will be seen alongside the ack
      upd_d = UPD_ONE << sel_d;
    end

    if (w_rd) begin
      case (w_reg)
        REG_ACTIVE:  dat_d = 32'(sel_q);
        REG_CTRL: begin
          dat_d[CTRL_HOLD_BIT]  = hold_q;
          dat_d[CTRL_CLKEN_BIT] = clk_en_q;
        end
        REG_COMPARE: dat_d = 32'(compare_q);
        REG_STATUS:  dat_d = w_status;
`ifdef SCRATCH_REG_EN
        REG_SCRATCH: dat_d = scratch_q;
`endif
        default:     dat_d = '0;
      endcase
    end
  end

  // Register bank; async reset aborts any transfer in flight
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      sel_q     <= '0;
      hold_q    <= 1'b0;
      clk_en_q  <= 1'b0;
      compare_q <= '0;
      upd_q     <= '0;
`ifdef SCRATCH_REG_EN
      scratch_q <= '0;
`endif
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      clk_en_q  <= clk_en_d;
      compare_q <= compare_d;
      upd_q     <= upd_d;
`ifdef SCRATCH_REG_EN
      scratch_q <= scratch_d;
`endif
    end
  end

  // While hold_reset is set the counter is kept loaded, so releasing hold
  // still yields a full RST_CYCLES tail of reset.
  mph_reset_stretch #(
    .RST_CYCLES (RST_CYCLES)
  ) u_stretch (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .load  (w_reload | hold_q),
    .busy  (w_busy),
    .cnt   (w_cnt)
  );

  assign wbs_ack_o        = ack_q;
  assign wbs_dat_o        = dat_q;
  assign proj_sel_o       = sel_q;
  assign proj_clk_en_o    = clk_en_q;
  assign proj_reset_o     = hold_q | w_busy;
  assign proj_wb_update_o = upd_q;
  assign compare_o        = compare_q;

  // Byte-lane and address bits that some configurations do not consume
  assign w_unused = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

endmodule

`default_nettype wire

// File: tb/tb_mph_wb_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mph_wb_ctrl
// Brief    : Self-checking bench for mph_wb_ctrl. Directed vector table,
//            hand-written multi-cycle sequences and randomized transfers
//            compared against a time-based behavioural model.
//            Honours SCRATCH_REG_EN when defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mph_wb_ctrl;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] dat_o;
  logic [2:0]  psel;
  logic        clken, prst;
  logic [7:0]  upd;
  logic [23:0] cmp;

  always #5 clk = ~clk;

  mph_wb_ctrl #(
    .NUM_PROJECTS (8),
    .BASE_ADDR    (32'h3000_0000),
    .COMPARE_W    (24),
    .RST_CYCLES   (R)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_n_i       (rst_n),
    .wbs_stb_i        (stb),
    .wbs_cyc_i        (cyc),
    .wbs_we_i         (we),
    .wbs_sel_i        (sel),
    .wbs_adr_i        (adr),
    .wbs_dat_i        (dat),
    .wbs_ack_o        (ack),
    .wbs_dat_o        (dat_o),
    .proj_sel_o       (psel),
    .proj_clk_en_o    (clken),
    .proj_reset_o     (prst),
    .proj_wb_update_o (upd),
    .compare_o        (cmp)
  );

  int checks = 0;
  int errors = 0;
  int cc = 0;
  always @(posedge clk) cc <= cc + 1;

  // Behavioural model: project reset is high while hold is set or until the
  // cycle m_rst_end (exclusive) after the most recent reload event.
  logic [3:0]  m_sel;
  bit          m_hold, m_clken;
  logic [31:0] m_cmp, m_scr;
  int          m_rst_end;

  function automatic bit m_reset_at(input int t);
    return m_hold || (t < m_rst_end);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off, input int t);
    int c;
    c = m_hold ? R : (((m_rst_end - t) > 0) ? (m_rst_end - t) : 0);
    case (off)
      8'h00: return {28'd0, m_sel};
      8'h04: return {30'd0, m_clken, m_hold};
      8'h08: return m_cmp;
      8'h0C: return {16'd0, c[7:0], m_sel, 3'd0, m_reset_at(t)};
`ifdef SCRATCH_REG_EN
      8'h10: return m_scr;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] off, input logic [31:0] d,
                         input logic [3:0] s, input int k);
    case (off)
      8'h00: if (s[0] && d[3:0] < 8 && d[3:0] != m_sel) begin
        m_sel = d[3:0];
        m_rst_end = k + R;
      end
      8'h04: if (s[0]) begin
        if (m_hold || d[0]) m_rst_end = k + R;
        m_hold  = d[0];
        m_clken = d[1];
      end
      8'h08: for (int b = 0; b < 3; b++) if (s[b]) m_cmp[b*8 +: 8] = d[b*8 +: 8];
`ifdef SCRATCH_REG_EN
      8'h10: for (int b = 0; b < 4; b++) if (s[b]) m_scr[b*8 +: 8] = d[b*8 +: 8];
`endif
      default: ;
    endcase
  endtask

  task automatic m_init();
    m_sel = 0; m_hold = 0; m_clken = 0; m_cmp = 0; m_scr = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cc);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " compare"}, 32'(cmp), m_cmp);
    chk({tag, " proj_sel"}, 32'(psel), 32'(m_sel));
    chk({tag, " clk_en"}, 32'(clken), 32'(m_clken));
    chk({tag, " proj_reset"}, 32'(prst), 32'(m_reset_at(cc)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle ack", 32'(ack), 0);
      chk("idle dat_o", dat_o, 0);
      chk("idle update", 32'(upd), 0);
      check_state("idle");
    end
  endtask

  // One Wishbone transfer; returns at the sample where ack is expected
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output logic [31:0] rd, output bit acked);
    bit          hit;
    logic [7:0]  off;
    logic [31:0] exp_rd;
    hit = (a[31:8] == 24'h30_0000);
    off = {a[7:2], 2'b00};
    @(negedge clk);
    adr = a; dat = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
    exp_rd = w ? 32'd0 : m_read(off, cc);
    @(negedge clk);
    acked = ack;
    rd    = dat_o;
    if (hit) begin
      chk("ack", 32'(ack), 1);
      if (w) m_write(off, d, s, cc);
      chk("rdata", dat_o, exp_rd);
      chk("update", 32'(upd), w ? (32'd1 << m_sel) : 32'd0);
      check_state("xfer");
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk("offbase ack", 32'(ack), 0);
        chk("offbase dat_o", dat_o, 0);
        chk("offbase update", 32'(upd), 0);
        if (i < 2) @(negedge clk);
      end
      check_state("offbase");
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (prst === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Release reset at a falling edge and check the stretched reset pulse
  task automatic do_release();
    int n;
    rst_n = 1'b1;
    m_init();
    m_rst_end = cc + R;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (prst) n++;
      chk("release proj_reset", 32'(prst), 32'(m_reset_at(cc)));
      @(negedge clk);
    end
    chk("release pulse length", n, R);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        exp_ack;
    logic [31:0] exp_rd;
    logic [31:0] exp_cmp;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t        tbl[17];
  logic [31:0] rd;
  bit          ak;
  int          n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h3000_000C, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0,        32'h0,      4'd0};
    tbl[1]  = '{32'h3000_0000, 32'h2,         4'hF, 1'b1, 1'b1, 32'h0,        32'h0,      4'd2};
    tbl[2]  = '{32'h3000_0008, 32'h0012_3456, 4'hF, 1'b1, 1'b1, 32'h0,        32'h123456, 4'd2};
    tbl[3]  = '{32'h3000_0008, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0012_3456, 32'h123456, 4'd2};
    tbl[4]  = '{32'h3000_0000, 32'h9,         4'hF, 1'b1, 1'b1, 32'h0,        32'h123456, 4'd2};
    tbl[5]  = '{32'h3000_0008, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0,        32'h0,      4'd2};
    tbl[6]  = '{32'h3000_0008, 32'hAABB_CCDD, 4'h2, 1'b1, 1'b1, 32'h0,        32'h00CC00, 4'd2};
    tbl[7]  = '{32'h3000_0008, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0000_CC00, 32'h00CC00, 4'd2};
    tbl[8]  = '{32'h3000_0020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0,        32'h00CC00, 4'd2};
    tbl[9]  = '{32'h3000_0100, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0,        32'h00CC00, 4'd2};
    tbl[10] = '{32'h3000_0000, 32'h5,         4'hE, 1'b1, 1'b1, 32'h0,        32'h00CC00, 4'd2};
    tbl[11] = '{32'h3000_0000, 32'h0,         4'hF, 1'b0, 1'b1, 32'h2,        32'h00CC00, 4'd2};
    tbl[12] = '{32'h3000_0004, 32'h2,         4'h1, 1'b1, 1'b1, 32'h0,        32'h00CC00, 4'd2};
    tbl[13] = '{32'h3000_0004, 32'h0,         4'hF, 1'b0, 1'b1, 32'h2,        32'h00CC00, 4'd2};
    tbl[14] = '{32'h3000_000C, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0,        32'h00CC00, 4'd2};
    tbl[15] = '{32'h3000_0004, 32'h0,         4'hF, 1'b0, 1'b1, 32'h2,        32'h00CC00, 4'd2};
    tbl[16] = '{32'h3000_0008, 32'h1122_3344, 4'h8, 1'b1, 1'b1, 32'h0,        32'h00CC00, 4'd2};

    rst_n = 1'b0; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat = 0;
    m_init();
    repeat (3) @(negedge clk);
    chk("reset ack", 32'(ack), 0);
    chk("reset dat_o", dat_o, 0);
    chk("reset proj_sel", 32'(psel), 0);
    chk("reset compare", 32'(cmp), 0);
    chk("reset update", 32'(upd), 0);
    chk("reset clk_en", 32'(clken), 0);
    chk("reset proj_reset", 32'(prst), 1);
    do_release();

    // Directed vector table
    foreach (tbl[i]) begin
      xfer(tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].we, rd, ak);
      chk($sformatf("vec%0d ack", i), 32'(ak), 32'(tbl[i].exp_ack));
      if (tbl[i].exp_ack && !tbl[i].we) chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d compare", i), 32'(cmp), tbl[i].exp_cmp);
      chk($sformatf("vec%0d proj_sel", i), 32'(psel), 32'(tbl[i].exp_sel));
    end
    idle(6);

    // ACTIVE change -> 4-cycle pulse; illegal and repeated values do not reload
    xfer(32'h3000_0000, 32'h3, 4'hF, 1'b1, rd, ak);
    count_high(n);
    chk("active3 pulse length", n, R);
    chk("active3 sel", 32'(psel), 3);
    idle(2);
    xfer(32'h3000_0000, 32'h9, 4'hF, 1'b1, rd, ak);
    chk("active9 acked", 32'(ak), 1);
    chk("active9 sel", 32'(psel), 3);
    chk("active9 no reload", 32'(prst), 0);
    xfer(32'h3000_0000, 32'h3, 4'hF, 1'b1, rd, ak);
    chk("active same no reload", 32'(prst), 0);
    idle(2);

    // hold_reset keeps reset high; release gives a full stretch tail
    xfer(32'h3000_0004, 32'h1, 4'hF, 1'b1, rd, ak);
    idle(12);
    chk("hold reset high", 32'(prst), 1);
    xfer(32'h3000_0004, 32'h2, 4'hF, 1'b1, rd, ak);
    count_high(n);
    chk("hold release tail", n, R);
    chk("hold release clk_en", 32'(clken), 1);
    idle(2);

    // Back-to-back requests are acked every other cycle
    @(negedge clk);
    adr = 32'h3000_0000; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b ack%0d", i), 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b dat%0d", i), dat_o, (i % 2 == 0) ? 32'd3 : 32'd0);
    end
    stb = 1'b0; cyc = 1'b0;
    idle(2);

    // SCRATCH readback
    xfer(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, rd, ak);
    xfer(32'h3000_0010, 32'h0, 4'hF, 1'b0, rd, ak);
`ifdef SCRATCH_REG_EN
    chk("scratch readback", rd, 32'hDEAD_BEEF);
`else
    chk("scratch readback", rd, 32'h0);
`endif

    // Randomized transfers against the model
    for (int it = 0; it < 300; it++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      int          r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    a = 32'h3000_0000;
        2, 3:    a = 32'h3000_0008;
        4:       a = 32'h3000_0004;
        5:       a = 32'h3000_000C;
        6:       a = 32'h3000_0010;
        7:       a = 32'h3000_0000 | ($urandom_range(5, 63) << 2);
        8:       a = 32'h3000_0100;
        default: a = 32'h2000_0008;
      endcase
      if (a[31:8] == 24'h30_0000) a[1:0] = 2'($urandom_range(0, 3));
      d = $urandom;
      if (r == 4 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      s = 4'($urandom_range(0, 15));
      xfer(a, d, s, 1'($urandom_range(0, 1)), rd, ak);
      idle($urandom_range(0, 2));
    end

    // Reset asserted mid-transfer aborts with no ack
    @(negedge clk);
    adr = 32'h3000_0008; dat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    #2 rst_n = 1'b0;
    m_init();
    @(negedge clk);
    chk("abort ack", 32'(ack), 0);
    chk("abort compare", 32'(cmp), 0);
    chk("abort update", 32'(upd), 0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    do_release();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
